axi_ethernet_v3_01_a_axi2ipic: RTL and testbench
================================================

# axi_ethernet_v3_01_a_axi2ipic

AXI4-Lite slave to IPIC initiator bridge for the Ethernet register space. It converts single-beat AXI4-Lite reads and writes into IPIC transactions (bus2ip_cs/rdce/wrce/addr/data/be) toward the IPIC decode/mux block, and waits for its one-cycle ip2bus_rdack/wrack/error pulses. It enforces one outstanding transaction, bus turnaround, and a timeout so that an unclaimed address never hangs the AXI bus.

## Interface
- C_S_AXI_ADDR_WIDTH, 12, AXI/IPIC address width; IPIC mux decodes bits [10:8].
- C_TIMEOUT_CYCLES, 64, strobe-asserted cycles without ack before forced SLVERR completion; legal range 4..255.
- s_axi_aclk  in  1  single clock, also drives IPIC.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data/response.
- bus2ip_addr  out  ADDR_W  latched address, bits [1:0] forced 0.
- bus2ip_data  out  32  latched wdata.
- bus2ip_be  out  4  wstrb on writes, 4'hF on reads.
- bus2ip_cs, bus2ip_rdce, bus2ip_wrce  out  1 each  IPIC strobes, level-held until completion.
- ip2bus_rdack, ip2bus_wrack, ip2bus_error  in  1 each  single-cycle pulses from mux.
- ip2bus_data  in  32  valid in ip2bus_rdack cycle.

## Operation
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE accepts only when turnaround counter gap==0. Write is eligible when awvalid & wvalid both high; read when arvalid high.
- Arbitration when both eligible: opposite of last served type; after reset, read first. Lone eligible type is always taken.
- Write accept: awready and wready pulse together for one cycle; latch addr, wdata, wstrb -> WR_REQ. Read accept: arready pulses one cycle; latch addr -> RD_REQ. Ready outputs never high outside IDLE.
- WR_REQ/RD_REQ: bus2ip_cs plus wrce/rdce held high; timeout counter loaded with C_TIMEOUT_CYCLES on entry, decremented each cycle.
- Completion event in RD_REQ: ip2bus_rdack or ip2bus_error or counter==0. In WR_REQ: ip2bus_wrack or ip2bus_error or counter==0. Acks of the wrong type and all acks in IDLE/RESP states are ignored.
- On completion: strobes drop, gap loaded with 2, go to *_RESP. resp = 2'b10 (SLVERR) if error or timeout, else 2'b00. rdata = ip2bus_data on clean rdack, 32'h0 on error/timeout.
- *_RESP: bvalid/rvalid held with stable resp/rdata until bready/rready; then IDLE.
- gap decrements to 0 in any state; guarantees ≥2 strobe-low cycles between transactions (covers mux registered decode and ack edge detection).
- Ack and timeout expiring in the same cycle: ack wins (OKAY, real data) unless error also high.

## Timing
- Reset (async, immediate): all outputs 0, state IDLE, gap 0, last-served=write (so read first). Reset mid-transaction drops strobes at once; pending response discarded.
- Cycle 0 AXI address handshake; cycle 1 strobes high; ack at cycle A; cycle A+1 strobes low and bvalid/rvalid high.
- With IPIC mux (registered decode + registered ack), minimum A = 4, so minimum accept-to-valid = 5 cycles.
- Timeout: strobes high exactly C_TIMEOUT_CYCLES cycles, response valid next cycle.
- Back-to-back throughput: next accept no earlier than 2 cycles after strobes fall and after previous response handshake.
- No combinational path from AXI inputs to AXI outputs or from ip2bus_* to any output.

## Test plan
- Write 0x404 data 0xDEADBEEF wstrb 0xF, wrack at cycle 4 -> bus2ip_wrce high cycles 1-4, be=0xF, bvalid cycle 5, bresp=00.
- Read 0x208, rdack with data 0x12345678 at cycle 4, rready held low 3 cycles -> rvalid held, rdata=0x12345678, rresp=00 stable until rready.
- Read 0x100 (no responder) -> strobes high 64 cycles, rvalid with rresp=10, rdata=0.
- Write with ip2bus_error+wrack same cycle -> bresp=10; stray rdack during write ignored.
- arvalid and awvalid/wvalid high simultaneously out of reset -> read served first, write next; strobes low ≥2 cycles between; unaligned address 0x407 appears as 0x404.
- Assert s_axi_aresetn low while rdce high -> rdce, cs, rvalid 0 same cycle; after release new write completes normally.

Source files
------------

// File: rtl/axi_ethernet_v3_01_a_axi2ipic.sv
// ---------------------------------------------------------------------------
// axi_ethernet_v3_01_a_axi2ipic
//
// AXI4-Lite slave to IPIC initiator bridge for the Ethernet register space.
// Each single-beat AXI4-Lite read or write becomes one IPIC transaction with
// level-held strobes. The strobes stay high until the IPIC side returns a
// matching ack, an error, or the timeout expires. Only one transaction is
// outstanding at a time, and a turnaround gap keeps the strobes low between
// transactions. Every output comes straight from a flop.
//
// Ports
//   s_axi_aclk, s_axi_aresetn     clock, async active-low reset
//   s_axi_aw*/w*/b*               AXI4-Lite write address/data/response
//   s_axi_ar*/r*                  AXI4-Lite read address/data/response
//   bus2ip_addr/data/be           latched IPIC address (word aligned), wdata, byte enables
//   bus2ip_cs/rdce/wrce           IPIC strobes, held until completion
//   ip2bus_rdack/wrack/error      single-cycle completion pulses
//   ip2bus_data                   read data, valid with ip2bus_rdack
// ---------------------------------------------------------------------------
module axi_ethernet_v3_01_a_axi2ipic #(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_TIMEOUT_CYCLES   = 64
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] bus2ip_addr,
  output logic [31:0]                   bus2ip_data,
  output logic [3:0]                    bus2ip_be,
  output logic                          bus2ip_cs,
  output logic                          bus2ip_rdce,
  output logic                          bus2ip_wrce,
  input  logic                          ip2bus_rdack,
  input  logic                          ip2bus_wrack,
  input  logic                          ip2bus_error,
  input  logic [31:0]                   ip2bus_data
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] ADDR_MASK   = {{(AW-2){1'b1}}, 2'b00};
  // Loaded with N-1 so that a countdown to zero gives exactly N strobe cycles.
  localparam logic [7:0]    TMO_LOAD    = 8'(C_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic            cs_q, cs_d, rdce_q, rdce_d, wrce_q, wrce_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      be_q, be_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [1:0]      gap_q, gap_d;
  logic            last_wr_q, last_wr_d;

  logic            ready_busy, can_offer, wr_elig, rd_elig, pick_rd;
  logic            offer_wr, offer_rd, wr_hs, rd_hs, tmo_zero, wr_done, rd_done;

  // Ready is registered, so it is offered one cycle after a request is seen;
  // while an offer is out no new decision is taken, which makes it a one-cycle pulse.
  assign ready_busy = awready_q | arready_q;
  assign can_offer  = (state_q == ST_IDLE) && !ready_busy && (gap_q == 2'd0);
  assign wr_elig    = s_axi_awvalid & s_axi_wvalid;
  assign rd_elig    = s_axi_arvalid;
  // Read wins a tie when the last served transfer was a write (also after reset).
  assign pick_rd    = rd_elig & (~wr_elig | last_wr_q);
  assign offer_rd   = can_offer & pick_rd;
  assign offer_wr   = can_offer & wr_elig & ~pick_rd;
  assign wr_hs      = awready_q & s_axi_awvalid & wready_q & s_axi_wvalid;
  assign rd_hs      = arready_q & s_axi_arvalid;
  assign tmo_zero   = (tmo_q == 8'd0);
  assign wr_done    = (state_q == ST_WR_REQ) & (ip2bus_wrack | ip2bus_error | tmo_zero);
  assign rd_done    = (state_q == ST_RD_REQ) & (ip2bus_rdack | ip2bus_error | tmo_zero);

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_hs) begin
          state_d = ST_WR_REQ;
        end else if (rd_hs) begin
          state_d = ST_RD_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ:  state_d = wr_done ? ST_WR_RESP : ST_WR_REQ;
      ST_RD_REQ:  state_d = rd_done ? ST_RD_RESP : ST_RD_REQ;
      ST_WR_RESP: state_d = s_axi_bready ? ST_IDLE : ST_WR_RESP;
      ST_RD_RESP: state_d = s_axi_rready ? ST_IDLE : ST_RD_RESP;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; outputs decode the next state so they leave a flop.
  always_comb begin
    awready_d = offer_wr;
    wready_d  = offer_wr;
    arready_d = offer_rd;
    cs_d      = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    wrce_d    = (state_d == ST_WR_REQ);
    rdce_d    = (state_d == ST_RD_REQ);
    bvalid_d  = (state_d == ST_WR_RESP);
    rvalid_d  = (state_d == ST_RD_RESP);

    if (wr_hs) begin
      addr_d = s_axi_awaddr & ADDR_MASK;
      data_d = s_axi_wdata;
      be_d   = s_axi_wstrb;
    end else if (rd_hs) begin
      addr_d = s_axi_araddr & ADDR_MASK;
      data_d = data_q;
      be_d   = 4'hF;
    end else begin
      addr_d = addr_q;
      data_d = data_q;
      be_d   = be_q;
    end

    if (wr_hs) begin
      last_wr_d = 1'b1;
    end else if (rd_hs) begin
      last_wr_d = 1'b0;
    end else begin
      last_wr_d = last_wr_q;
    end

    if (wr_hs || rd_hs) begin
      tmo_d = TMO_LOAD;
    end else if (cs_q && !tmo_zero) begin
      tmo_d = tmo_q - 8'd1;
    end else begin
      tmo_d = tmo_q;
    end

    if (wr_done || rd_done) begin
      gap_d = 2'd2;
    end else if (gap_q != 2'd0) begin
      gap_d = gap_q - 2'd1;
    end else begin
      gap_d = gap_q;
    end

    // A real ack beats a simultaneous timeout unless error is also raised.
    if (wr_done) begin
      bresp_d = (ip2bus_error || !ip2bus_wrack) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      bresp_d = bresp_q;
    end

    if (rd_done) begin
      rresp_d = (ip2bus_error || !ip2bus_rdack) ? RESP_SLVERR : RESP_OKAY;
      rdata_d = (ip2bus_rdack && !ip2bus_error) ? ip2bus_data : 32'h0000_0000;
    end else begin
      rresp_d = rresp_q;
      rdata_d = rdata_q;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      cs_q      <= 1'b0;
      rdce_q    <= 1'b0;
      wrce_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= 32'h0000_0000;
      be_q      <= 4'h0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0000_0000;
      tmo_q     <= 8'd0;
      gap_q     <= 2'd0;
      last_wr_q <= 1'b1;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      cs_q      <= cs_d;
      rdce_q    <= rdce_d;
      wrce_q    <= wrce_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign bus2ip_addr   = addr_q;
  assign bus2ip_data   = data_q;
  assign bus2ip_be     = be_q;
  assign bus2ip_cs     = cs_q;
  assign bus2ip_rdce   = rdce_q;
  assign bus2ip_wrce   = wrce_q;

endmodule

// File: tb/tb_axi_ethernet_v3_01_a_axi2ipic.sv
// ---------------------------------------------------------------------------
// Bench for axi_ethernet_v3_01_a_axi2ipic: directed AXI-Lite transfers with a
// transaction-level reference model checked every cycle, plus literal pins.
// ---------------------------------------------------------------------------
module tb_axi_ethernet_v3_01_a_axi2ipic;
  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] s_axi_awaddr, s_axi_araddr, bus2ip_addr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata, bus2ip_data, ip2bus_data;
  logic [3:0]  s_axi_wstrb, bus2ip_be;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        bus2ip_cs, bus2ip_rdce, bus2ip_wrce;
  logic        ip2bus_rdack, ip2bus_wrack, ip2bus_error;

  axi_ethernet_v3_01_a_axi2ipic #(.C_S_AXI_ADDR_WIDTH(12), .C_TIMEOUT_CYCLES(TMO)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .bus2ip_addr(bus2ip_addr),
    .bus2ip_data(bus2ip_data), .bus2ip_be(bus2ip_be), .bus2ip_cs(bus2ip_cs),
    .bus2ip_rdce(bus2ip_rdce), .bus2ip_wrce(bus2ip_wrce), .ip2bus_rdack(ip2bus_rdack),
    .ip2bus_wrack(ip2bus_wrack), .ip2bus_error(ip2bus_error), .ip2bus_data(ip2bus_data)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record (free / strobing / responding).
  int          cyc = 0;
  int          m_phase, m_elapsed, m_fall, m_stall;
  bit          m_wr, m_last_wr;
  logic [11:0] m_addr;
  logic [31:0] m_data, m_rdata;
  logic [3:0]  m_be;
  logic [1:0]  m_resp;
  // Raw observations of the DUT, pinned against literals by the stimulus.
  int          obs_hs, obs_cnt, obs_lat, obs_lowrun, low_run;
  logic [11:0] obs_addr;
  logic [3:0]  obs_be;
  logic [1:0]  obs_resp;
  logic [31:0] obs_rdata;
  logic [7:0]  obs_hist;
  bit          prev_cs, prev_v;

  always @(negedge clk) begin : compare
    bit hs_w, hs_r, ack, err;
    if (!rst_n) begin
      chk("rst_ctrl", {20'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                       s_axi_rvalid, bus2ip_cs, bus2ip_rdce, bus2ip_wrce, s_axi_bresp, s_axi_rresp}, 32'd0);
      chk("rst_addr", {20'd0, bus2ip_addr}, 32'd0);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      chk("rst_bdata", bus2ip_data, 32'd0);
      chk("rst_be", {28'd0, bus2ip_be}, 32'd0);
      m_phase = 0; m_last_wr = 1'b1; m_fall = -100; m_stall = 0;
    end else begin
      chk("cs",   bus2ip_cs,   32'(m_phase == 1));
      chk("wrce", bus2ip_wrce, 32'(m_phase == 1 && m_wr));
      chk("rdce", bus2ip_rdce, 32'(m_phase == 1 && !m_wr));
      chk("bvalid", s_axi_bvalid, 32'(m_phase == 2 && m_wr));
      chk("rvalid", s_axi_rvalid, 32'(m_phase == 2 && !m_wr));
      if (m_phase == 1) begin
        chk("bus2ip_addr", {20'd0, bus2ip_addr}, {20'd0, m_addr});
        chk("bus2ip_be", {28'd0, bus2ip_be}, {28'd0, m_be});
        if (m_wr) chk("bus2ip_data", bus2ip_data, m_data);
      end
      if (m_phase == 2 && m_wr) chk("bresp", {30'd0, s_axi_bresp}, {30'd0, m_resp});
      if (m_phase == 2 && !m_wr) begin
        chk("rresp", {30'd0, s_axi_rresp}, {30'd0, m_resp});
        chk("rdata", s_axi_rdata, m_rdata);
      end
      if (m_phase != 0) begin
        chk("ready_busy", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
      end else begin
        chk("aw_w_ready_pair", s_axi_awready, {31'd0, s_axi_wready});
        if (s_axi_awready || s_axi_arready) begin
          chk("one_ready", 32'(s_axi_awready && s_axi_arready), 32'd0);
          chk("turnaround", 32'((cyc - m_fall) >= 2), 32'd1);
        end
      end
      // Advance the model with this cycle's inputs.
      hs_w = s_axi_awready && s_axi_awvalid && s_axi_wready && s_axi_wvalid;
      hs_r = s_axi_arready && s_axi_arvalid;
      case (m_phase)
        0: begin
          if (hs_w || hs_r) begin
            if (s_axi_awvalid && s_axi_wvalid && s_axi_arvalid) chk("arb_order", 32'(hs_r), 32'(m_last_wr));
            m_wr = hs_w; m_last_wr = hs_w;
            m_addr = (hs_w ? s_axi_awaddr : s_axi_araddr) & 12'hFFC;
            m_be = hs_w ? s_axi_wstrb : 4'hF;
            if (hs_w) m_data = s_axi_wdata;
            m_phase = 1; m_elapsed = 0; m_stall = 0;
            obs_hs = cyc; obs_cnt = 0;
            obs_hist = {obs_hist[3:0], hs_r ? 4'h1 : 4'h2};
          end else if (((s_axi_awvalid && s_axi_wvalid) || s_axi_arvalid) && (cyc - m_fall) >= 2) begin
            m_stall++;
            chk("accept_stall", 32'(m_stall <= 4), 32'd1);
          end else begin
            m_stall = 0;
          end
        end
        1: begin
          m_elapsed++;
          ack = m_wr ? ip2bus_wrack : ip2bus_rdack;
          err = ip2bus_error;
          if (ack || err || m_elapsed >= TMO) begin
            m_resp = (err || !ack) ? 2'b10 : 2'b00;
            m_rdata = (!m_wr && ack && !err) ? ip2bus_data : 32'h0;
            m_phase = 2; m_fall = cyc + 1;
          end
        end
        default: begin
          if (m_wr ? s_axi_bready : s_axi_rready) m_phase = 0;
        end
      endcase
    end
    if (bus2ip_cs) obs_cnt++;
    if (bus2ip_cs && !prev_cs) begin
      obs_addr = bus2ip_addr; obs_be = bus2ip_be; obs_lowrun = low_run;
    end
    low_run = bus2ip_cs ? 0 : low_run + 1;
    if ((s_axi_bvalid || s_axi_rvalid) && !prev_v) begin
      obs_lat = cyc - obs_hs;
      obs_resp = s_axi_bvalid ? s_axi_bresp : s_axi_rresp;
      obs_rdata = s_axi_rdata;
    end
    prev_cs = bus2ip_cs;
    prev_v = s_axi_bvalid || s_axi_rvalid;
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // which: 0 awready, 1 arready, 2 bvalid, 3 rvalid; returns just after that edge.
  task automatic wait_for(input int which, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      case (which)
        0: ok = s_axi_awready;
        1: ok = s_axi_arready;
        2: ok = s_axi_bvalid;
        default: ok = s_axi_rvalid;
      endcase
      if (ok) break;
    end
    chk(nm, 32'(ok), 32'd1);
    step();
  endtask

  // Called in cycle 1; raises the given acks during cycle `at`.
  task automatic pulse_ack(input int at, input bit wr, input bit rd, input bit er, input logic [31:0] d);
    repeat (at - 1) step();
    ip2bus_wrack = wr; ip2bus_rdack = rd; ip2bus_error = er; ip2bus_data = d;
    step();
    ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b0; ip2bus_error = 1'b0; ip2bus_data = 32'hFFFF_0000;
  endtask

  task automatic start_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_axi_awaddr = 12'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 12'h0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; ip2bus_rdack = 1'b0; ip2bus_wrack = 1'b0; ip2bus_error = 1'b0;
    ip2bus_data = 32'h0; obs_hist = 8'h00; low_run = 0; prev_cs = 1'b0; prev_v = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Simultaneous read and write out of reset: read first, unaligned write address.
    obs_hist = 8'h00;
    s_axi_araddr = 12'h20C; s_axi_arvalid = 1'b1;
    start_write(12'h407, 32'hCAFE_F00D, 4'h3);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    wait_for(1, "arb_ar_hs");
    s_axi_arvalid = 1'b0;
    pulse_ack(4, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
    wait_for(3, "arb_rvalid");
    wait_for(0, "arb_aw_hs");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    pulse_ack(3, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_for(2, "arb_bvalid");
    chk("arb_hist_read_then_write", {24'd0, obs_hist}, 32'h12);
    chk("unaligned_addr", {20'd0, obs_addr}, 32'h404);
    chk("arb_write_be", {28'd0, obs_be}, 32'h3);
    chk("strobe_low_ge2", 32'(obs_lowrun >= 2), 32'd1);

    // Write 0x404, wrack in cycle 4.
    start_write(12'h404, 32'hDEAD_BEEF, 4'hF);
    wait_for(0, "wr_aw_hs");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    pulse_ack(4, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_for(2, "wr_bvalid");
    chk("wr_wrce_cycles", obs_cnt, 32'd4);
    chk("wr_latency", obs_lat, 32'd5);
    chk("wr_bresp", {30'd0, obs_resp}, 32'd0);
    chk("wr_be", {28'd0, obs_be}, 32'hF);

    // Read 0x208, rdack in cycle 4, rready held low for 3 cycles.
    s_axi_rready = 1'b0;
    s_axi_araddr = 12'h208; s_axi_arvalid = 1'b1;
    wait_for(1, "rd_ar_hs");
    s_axi_arvalid = 1'b0;
    pulse_ack(4, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    wait_for(3, "rd_rvalid");
    chk("rd_rvalid_held", {31'd0, s_axi_rvalid}, 32'd1);
    step(); step();
    s_axi_rready = 1'b1;
    wait_for(3, "rd_rvalid_hs");
    chk("rd_rdata", obs_rdata, 32'h1234_5678);
    chk("rd_rresp", {30'd0, obs_resp}, 32'd0);
    chk("rd_latency", obs_lat, 32'd5);

    // Read 0x100 with no responder: timeout.
    s_axi_araddr = 12'h100; s_axi_arvalid = 1'b1;
    wait_for(1, "tmo_ar_hs");
    s_axi_arvalid = 1'b0;
    wait_for(3, "tmo_rvalid");
    chk("tmo_strobe_cycles", obs_cnt, 32'd64);
    chk("tmo_rresp", {30'd0, obs_resp}, 32'h2);
    chk("tmo_rdata", obs_rdata, 32'd0);
    chk("tmo_latency", obs_lat, 32'd65);

    // Write 0x408 with stray rdack in cycle 2, then error+wrack in cycle 3.
    start_write(12'h408, 32'h0BAD_F00D, 4'hC);
    wait_for(0, "err_aw_hs");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    pulse_ack(2, 1'b0, 1'b1, 1'b0, 32'h1111_1111);
    ip2bus_wrack = 1'b1; ip2bus_error = 1'b1;
    step();
    ip2bus_wrack = 1'b0; ip2bus_error = 1'b0;
    wait_for(2, "err_bvalid");
    chk("err_wrce_cycles", obs_cnt, 32'd3);
    chk("err_bresp", {30'd0, obs_resp}, 32'h2);
    chk("err_latency", obs_lat, 32'd4);

    // Stray acks while idle are ignored.
    pulse_ack(1, 1'b1, 1'b0, 1'b0, 32'h0);
    pulse_ack(1, 1'b0, 1'b1, 1'b1, 32'h2222_2222);
    step(); step();
    chk("idle_cs", {31'd0, bus2ip_cs}, 32'd0);

    // Reset while rdce is high, then a normal write.
    s_axi_araddr = 12'h208; s_axi_arvalid = 1'b1;
    wait_for(1, "rst_ar_hs");
    s_axi_arvalid = 1'b0;
    step();
    chk("pre_rst_rdce", {31'd0, bus2ip_rdce}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdce", {31'd0, bus2ip_rdce}, 32'd0);
    chk("async_rst_cs", {31'd0, bus2ip_cs}, 32'd0);
    chk("async_rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    start_write(12'h40C, 32'h1357_9BDF, 4'hF);
    wait_for(0, "post_rst_aw_hs");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    pulse_ack(4, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_for(2, "post_rst_bvalid");
    chk("post_rst_bresp", {30'd0, obs_resp}, 32'd0);
    chk("post_rst_latency", obs_lat, 32'd5);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
